nonrestoring_div: RTL and testbench

//   Sequential radix-2 non-restoring signed divider; the inverse of the shift-add multipliers in Multipliers/.

---
 rtl/nonrestoring_div.sv | 141 ++++++++++++++
 tb/tb_nonrestoring_div.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_div.sv
// Sequential radix-2 non-restoring signed divider: one quotient bit per clock,
// start/busy/done handshake, truncating quotient and dividend-signed remainder.
module nonrestoring_div #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] z,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [N:0]    p, p_n;
  logic [N-1:0]  a, a_n;
  logic [N-1:0]  dm, dm_n;
  logic          sz, sz_n, sd, sd_n;
  logic          dz_pend, dz_pend_n, ov_pend, ov_pend_n;
  logic [N-1:0]  q_n, r_n;
  logic          busy_n, done_n, dbz_n, ovf_n;

  logic [N-1:0]  z_abs, d_abs, r_mag;
  logic [N:0]    p_shift, p_step, p_fix;

  // Magnitudes are N-bit unsigned, so |-2^(N-1)| = 2^(N-1) is representable.
  assign z_abs   = z[N-1] ? -z : z;
  assign d_abs   = d[N-1] ? -d : d;
  assign p_shift = {p[N-1:0], a[N-1]};
  assign p_step  = p[N] ? p_shift + {1'b0, dm} : p_shift - {1'b0, dm};
  assign p_fix   = p[N] ? p + {1'b0, dm} : p;
  assign r_mag   = p_fix[N-1:0];

  // Next-state and next-output logic; a holds the dividend and collects quotient bits.
  always_comb begin
    state_n   = state;
    count_n   = count;
    p_n       = p;
    a_n       = a;
    dm_n      = dm;
    sz_n      = sz;
    sd_n      = sd;
    dz_pend_n = dz_pend;
    ov_pend_n = ov_pend;
    q_n       = q;
    r_n       = r;
    busy_n    = busy;
    done_n    = 1'b0;
    dbz_n     = div_by_zero;
    ovf_n     = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          sz_n      = z[N-1];
          sd_n      = d[N-1];
          a_n       = z_abs;
          dm_n      = d_abs;
          p_n       = '0;
          count_n   = '0;
          busy_n    = 1'b1;
          dz_pend_n = (d == '0);
          ov_pend_n = (z == MIN_NEG) && (d == '1);
          state_n   = ((d == '0) || ((z == MIN_NEG) && (d == '1))) ? FIX : RUN;
        end
      end
      RUN: begin
        p_n     = p_step;
        a_n     = {a[N-2:0], ~p_step[N]};
        count_n = count + CW'(1);
        if (count == CW'(N-1)) state_n = FIX;
      end
      FIX: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        dbz_n   = dz_pend;
        ovf_n   = ov_pend;
        p_n     = p_fix;
        if (dz_pend) begin
          q_n = '1;
          r_n = sz ? -a : a;
        end else if (ov_pend) begin
          q_n = MIN_NEG;
          r_n = '0;
        end else begin
          q_n = (sz ^ sd) ? -a : a;
          r_n = sz ? -r_mag : r_mag;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      p           <= '0;
      a           <= '0;
      dm          <= '0;
      sz          <= 1'b0;
      sd          <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      p           <= p_n;
      a           <= a_n;
      dm          <= dm_n;
      sz          <= sz_n;
      sd          <= sd_n;
      dz_pend     <= dz_pend_n;
      ov_pend     <= ov_pend_n;
      q           <= q_n;
      r           <= r_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
      overflow    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_nonrestoring_div.sv
// Bench for nonrestoring_div (N=8): directed corner cases plus a random sweep
// against an integer-arithmetic reference model.
module tb_nonrestoring_div;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] z, d;
  logic [N-1:0] q, r;
  logic         busy, done, div_by_zero, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  nonrestoring_div #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .z(z), .d(d),
    .q(q), .r(r), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: {q, r, div_by_zero, overflow} from plain signed arithmetic.
  function automatic logic [2*N+1:0] model(input logic [N-1:0] zi, input logic [N-1:0] di);
    int zs, ds, qs, rs;
    zs = int'($signed(zi));
    ds = int'($signed(di));
    if (ds == 0) return {8'hFF, zi, 1'b1, 1'b0};
    if (zs == -128 && ds == -1) return {8'h80, 8'h00, 1'b0, 1'b1};
    qs = zs / ds;
    rs = zs % ds;
    return {N'(qs), N'(rs), 1'b0, 1'b0};
  endfunction

  function automatic int exp_lat(input logic [N-1:0] zi, input logic [N-1:0] di);
    if (di == '0 || (zi == 8'h80 && di == 8'hFF)) return 1;
    return N + 1;
  endfunction

  // Called at posedge+1; pulses start for one edge and counts edges until done.
  task automatic run_op(input logic [N-1:0] zi, input logic [N-1:0] di, output int lat);
    z = zi; d = di; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    z = $urandom; d = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; z = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({q, r, busy, done, div_by_zero, overflow} !== '0)
      $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
               q, r, busy, done, div_by_zero, overflow);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    z = 8'd100; d = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy_set: busy=%b done=%b, want 1 0", busy, done);
    else n_pass++;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != N + 1) $display("FAIL basic_latency: got %0d edges, want %0d", lat, N + 1);
    else n_pass++;
    n_checks++;
    if ({q, r, busy, div_by_zero, overflow} !== {8'd14, 8'd2, 3'b000})
      $display("FAIL basic_100_7: got q=%0d r=%0d busy=%b dbz=%b ovf=%b, want 14 2 0 0 0",
               $signed(q), $signed(r), busy, div_by_zero, overflow);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_pulse_width: done=%b one cycle later, want 0", done);
    else n_pass++;
  endtask

  task automatic test_signs;
    logic [N-1:0] zt [6] = '{8'h9C, 8'd100, 8'h9C, 8'd3, 8'h80, 8'h80};
    logic [N-1:0] dt [6] = '{8'd7, 8'hF9, 8'hF9, 8'd7, 8'd3, 8'h80};
    logic [2*N+1:0] exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(zt[i], dt[i], lat);
      exp = model(zt[i], dt[i]);
      n_checks++;
      if ({q, r, div_by_zero, overflow} !== exp || lat != N + 1)
        $display("FAIL sign_case_%0d: z=%0d d=%0d got q=%0d r=%0d flags=%b%b lat=%0d, want q=%0d r=%0d flags=%b lat=%0d",
                 i, $signed(zt[i]), $signed(dt[i]), $signed(q), $signed(r), div_by_zero, overflow, lat,
                 $signed(exp[2*N+1:N+2]), $signed(exp[N+1:2]), exp[1:0], N + 1);
      else n_pass++;
    end
  endtask

  task automatic test_special;
    int lat;
    run_op(8'h80, 8'hFF, lat);
    n_checks++;
    if ({q, r, div_by_zero, overflow} !== {8'h80, 8'h00, 2'b01} || lat != 1)
      $display("FAIL overflow_case: got q=%h r=%h dbz=%b ovf=%b lat=%0d, want 80 00 0 1 lat=1",
               q, r, div_by_zero, overflow, lat);
    else n_pass++;
    run_op(8'd5, 8'd0, lat);
    n_checks++;
    if ({q, r, div_by_zero, overflow} !== {8'hFF, 8'h05, 2'b10} || lat != 1)
      $display("FAIL div_by_zero_case: got q=%h r=%h dbz=%b ovf=%b lat=%0d, want ff 05 1 0 lat=1",
               q, r, div_by_zero, overflow, lat);
    else n_pass++;
    run_op(8'hFB, 8'd0, lat);
    n_checks++;
    if ({q, r, div_by_zero} !== {8'hFF, 8'hFB, 1'b1})
      $display("FAIL div_by_zero_neg: got q=%h r=%h dbz=%b, want ff fb 1", q, r, div_by_zero);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int lat;
    z = 8'd100; d = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    z = 8'd1; d = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if ({q, r} !== {8'd14, 8'd2} || lat != N + 1)
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want 14 2 lat=%0d", q, r, lat, N + 1);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ignore_start_no_queue: busy=%b after done, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(8'd100, 8'd7, lat);
    z = 8'd50; d = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, q, r} !== {1'b1, 8'd14, 8'd2})
      $display("FAIL b2b_hold: got busy=%b q=%0d r=%0d, want 1 14 2", busy, q, r);
    else n_pass++;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if ({q, r} !== {8'd10, 8'd0} || lat != N + 1)
      $display("FAIL b2b_result: got q=%0d r=%0d lat=%0d, want 10 0 lat=%0d", q, r, lat, N + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    z = 8'd100; d = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({q, r, busy, done, div_by_zero, overflow} !== '0)
      $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b, want all 0", q, r, busy, done);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_mid_no_done: saw %0d done pulses, want 0", seen);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [N-1:0] zi, di;
    logic [2*N+1:0] exp;
    int lat;
    for (int i = 0; i < 3000; i++) begin
      zi = N'($urandom);
      di = N'($urandom);
      if (i % 50 == 0) di = '0;
      if (i % 37 == 0) zi = 8'h80;
      if (i % 111 == 0) di = 8'hFF;
      run_op(zi, di, lat);
      exp = model(zi, di);
      n_checks++;
      if ({q, r, div_by_zero, overflow} !== exp || lat != exp_lat(zi, di))
        $display("FAIL random_%0d: z=%0d d=%0d got q=%0d r=%0d flags=%b%b lat=%0d, want q=%0d r=%0d flags=%b lat=%0d",
                 i, $signed(zi), $signed(di), $signed(q), $signed(r), div_by_zero, overflow, lat,
                 $signed(exp[2*N+1:N+2]), $signed(exp[N+1:2]), exp[1:0], exp_lat(zi, di));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_special;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
